pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Control unit for a four-stage in-order pipeline (IF, RR, EX, WB). It
// sequences the RR, EX and WB stages, stalls RR on read-after-write hazards
// (there is no bypass), flushes two slots on a taken JZ, steers the two-word
// LI instruction and freezes the machine once SYS retires.
//
// Opcode encoding (if_op): 4'h1 JZSYSSZ (s==0 -> SYS, s!=0 -> JZ), 4'h2 LI,
// 4'h3 LD, 4'h4 ST; every other value is a register-writing ALU op (ADD...).
//
// Ports
//   clock       in   sole clock, rising edge
//   reset       in   asynchronous, active-low
//   if_op/s/d   in   fields of the word at the instruction-memory output
//   jump_taken  in   JZ condition from the ALU stage, used only for JZ in EX
//   pc_en       out  PC loads its next value
//   pc_sel      out  0 = PC increment, 1 = jump target
//   ifb_en      out  IF-to-RR instruction buffer loads
//   rr_bubble   out  RR-to-EX buffer loads a NOP
//   reg_we      out  register file write (WB stage)
//   wb_sel      out  0 = ALU result, 1 = memory data / LI immediate
//   mem_re      out  data memory read (EX stage)
//   mem_we      out  data memory write (EX stage)
//   halted      out  SYS has retired
//   li_phase    out  current fetch word is an LI immediate
module pipeline_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] if_op,
  input  logic [5:0] if_s,
  input  logic [5:0] if_d,
  input  logic       jump_taken,
  output logic       pc_en,
  output logic       pc_sel,
  output logic       ifb_en,
  output logic       rr_bubble,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       mem_re,
  output logic       mem_we,
  output logic       halted,
  output logic       li_phase
);

  localparam logic [3:0] OP_JZSYSSZ = 4'h1;
  localparam logic [3:0] OP_LI      = 4'h2;
  localparam logic [3:0] OP_LD      = 4'h3;
  localparam logic [3:0] OP_ST      = 4'h4;

  typedef struct packed {
    logic       valid;
    logic [3:0] op;
    logic [5:0] s;
    logic [5:0] d;
  } stage_t;

  typedef enum logic {CTRL_RUN, CTRL_HALT} ctrlState_t;

  ctrlState_t stateReg, stateNext;
  stage_t     rrReg, exReg, wbReg;
  stage_t     rrNext, exNext, wbNext;
  logic       liPhaseReg, liPhaseNext;

  logic pcEn, pcSel, ifbEn, rrBubble;
  logic sysInWb, haltNow, flush, hazard;
  logic [1:0] conflict;
  stage_t olderStage [2];

  function automatic logic isWriter(input stage_t st);
    return st.valid && (st.op != OP_ST) && (st.op != OP_JZSYSSZ);
  endfunction

  // LI carries its operand in the following word, so it reads no register.
  function automatic logic readsReg(input stage_t st, input logic [5:0] r);
    return st.valid && (st.op != OP_LI) && ((st.s == r) || (st.d == r));
  endfunction

  assign olderStage[0] = exReg;
  assign olderStage[1] = wbReg;

  // RR conflicts with any in-flight writer; WB writes land at the end of
  // the cycle, so a WB writer still blocks this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_conflict
      assign conflict[gi] = isWriter(olderStage[gi]) &&
                            readsReg(rrReg, olderStage[gi].d);
    end
  endgenerate

  assign hazard  = |conflict;
  assign sysInWb = wbReg.valid && (wbReg.op == OP_JZSYSSZ) && (wbReg.s == 6'd0);
  // Halt takes effect in the very cycle SYS sits in WB, so anything younger
  // is squashed before it can touch memory or the PC.
  assign haltNow = (stateReg == CTRL_HALT) || sysInWb;
  assign flush   = !haltNow && exReg.valid && (exReg.op == OP_JZSYSSZ) &&
                   (exReg.s != 6'd0) && jump_taken;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateReg   <= CTRL_RUN;
      rrReg      <= '0;
      exReg      <= '0;
      wbReg      <= '0;
      liPhaseReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      rrReg      <= rrNext;
      exReg      <= exNext;
      wbReg      <= wbNext;
      liPhaseReg <= liPhaseNext;
    end
  end

  always_comb begin
    stateNext   = sysInWb ? CTRL_HALT : stateReg;
    pcEn        = 1'b1;
    pcSel       = 1'b0;
    ifbEn       = 1'b1;
    rrBubble    = 1'b0;
    rrNext      = rrReg;
    exNext      = rrReg;
    wbNext      = exReg;
    liPhaseNext = liPhaseReg;

    if (haltNow) begin
      pcEn        = 1'b0;
      ifbEn       = 1'b0;
      rrBubble    = 1'b1;
      rrNext      = '0;
      exNext      = '0;
      wbNext      = '0;
      liPhaseNext = 1'b0;
    end else if (flush) begin
      // The buffer loads, but both the RR instruction and the IF word die.
      pcSel       = 1'b1;
      rrBubble    = 1'b1;
      rrNext      = '0;
      exNext      = '0;
      liPhaseNext = 1'b0;
    end else if (hazard) begin
      pcEn     = 1'b0;
      ifbEn    = 1'b0;
      rrBubble = 1'b1;
      exNext   = '0;
    end else begin
      // An LI immediate enters RR as a non-instruction so it is never decoded.
      rrNext      = {~liPhaseReg, if_op, if_s, if_d};
      liPhaseNext = ~liPhaseReg && (if_op == OP_LI);
    end
  end

  // Reset forces the fetch controls to their idle values without waiting
  // for a clock edge.
  assign pc_en     = reset & pcEn;
  assign ifb_en    = reset & ifbEn;
  assign rr_bubble = ~reset | rrBubble;
  assign pc_sel    = reset & pcSel;
  assign reg_we    = isWriter(wbReg);
  assign wb_sel    = wbReg.valid && ((wbReg.op == OP_LD) || (wbReg.op == OP_LI));
  assign mem_re    = !haltNow && exReg.valid && (exReg.op == OP_LD);
  assign mem_we    = !haltNow && exReg.valid && (exReg.op == OP_ST);
  assign halted    = haltNow;
  assign li_phase  = liPhaseReg;

endmodule
